// File: rtl/detect_window_counter.sv
// detect_window_counter: counts detector pulses per fixed window and hands results over with valid/ack
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset
//   en    - counting enable (RUN while high)
//   w     - detection pulse, sampled every edge
//   ack   - consumer accepts the current result
//   count - hits in the last completed window, saturating
//   valid - count holds an unconsumed result
//   sat   - the reported window saturated
//   lost  - a result was overwritten before being acknowledged (sticky until an accepted ack)
module detect_window_counter #(
  parameter int WIN = 16,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          w,
  input  logic          ack,
  output logic [CW-1:0] count,
  output logic          valid,
  output logic          sat,
  output logic          lost
);
  localparam int PW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [CW-1:0] MAX = '1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] cyc_q, cyc_d, cyc_cur;
  logic [CW-1:0] acc_q, acc_d, acc_cur, sum, count_q, count_d;
  logic          wsat_q, wsat_d, wsat_cur, valid_q, valid_d, sat_q, sat_d, lost_q, lost_d;
  logic          win_end, ovf;
  always_comb begin
    state_d  = en ? RUN : IDLE;
    // leaving IDLE always restarts at window cycle 0 with an empty accumulator
    cyc_cur  = (state_q == RUN) ? cyc_q : '0;
    acc_cur  = (state_q == RUN) ? acc_q : '0;
    wsat_cur = (state_q == RUN) & wsat_q;
    win_end  = en && (cyc_cur == PW'(WIN - 1));
    ovf      = (acc_cur == MAX) & w;
    sum      = ovf ? acc_cur : acc_cur + CW'(w);
    cyc_d    = (!en || win_end) ? '0 : cyc_cur + PW'(1);
    acc_d    = (!en || win_end) ? '0 : sum;
    wsat_d   = (!en || win_end) ? 1'b0 : wsat_cur | ovf;
    count_d  = win_end ? sum : count_q;
    sat_d    = win_end ? (wsat_cur | ovf) : sat_q;
    valid_d  = win_end | (valid_q & ~ack);
    // overwrite of an unacked result sets lost; any accepted ack clears it
    lost_d   = valid_q ? (win_end & ~ack) | (lost_q & ~ack) : lost_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      acc_q   <= '0;
      wsat_q  <= 1'b0;
      count_q <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      acc_q   <= acc_d;
      wsat_q  <= wsat_d;
      count_q <= count_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
      lost_q  <= lost_d;
    end
  end
  assign count = count_q;
  assign valid = valid_q;
  assign sat   = sat_q;
  assign lost  = lost_q;
endmodule
